cond_increment_stream: RTL and testbench
========================================

// Module: cond_increment_stream
// PURPOSE
//  Streaming, parametrised conditional-increment unit with valid/ready handshakes on both sides.
//  Each accepted word is compared against THRESHOLD and conditionally incremented by STEP.
//  The rule is selected per word by a 2-bit mode.
//  Two-stage registered pipeline with full back-pressure and a saturating count of incremented words.
//  Sits between a word source and a consumer in the arithmetic datapath test designs.
// PARAMETERS
//  WIDTH      32    data width in bits (>=2)
//  THRESHOLD  4096  compare constant; "over" means in_data > THRESHOLD (unsigned, strict)
//  STEP       1     increment amount, unsigned, < 2**WIDTH
//  CNT_W      16    width of inc_count
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input word valid
//  in_ready   out  1      unit can accept a word this cycle
//  in_data    in   WIDTH  input word, unsigned
//  in_mode    in   2      rule for this word, sampled together with in_data
//  out_valid  out  1      output word valid
//  out_ready  in   1      consumer accepts output this cycle
//  out_data   out  WIDTH  result word
//  out_incr   out  1      result includes the +STEP increment
//  out_ovf    out  1      increment wrapped or saturated at 2**WIDTH-1
//  count_clr  in   1      synchronous clear of inc_count
//  inc_count  out  CNT_W  number of delivered words with out_incr=1, saturating
// BEHAVIOUR
//  Reset: rst_n low asynchronously clears all registers.
//   - Values while reset is held: out_valid=0, out_data=0, out_incr=0, out_ovf=0, inc_count=0, in_ready=0.
//   - After release, in_ready=1 (pipe empty).
//  Handshakes:
//   - Input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
//   - out_* must stay stable while out_valid=1 && out_ready=0.
//  Pipeline: S1 registers {data, mode, over=(data>THRESHOLD), sum=data+STEP as WIDTH+1 bits}.
//   S2 registers the final result. Latency from input transfer to out_valid is 2 cycles.
//   - Stage advance: S2 loads when it is empty or out_ready=1. S1 loads when it is empty or S2 loads.
//   - in_ready = !s1_valid || s2_load (combinational). Sustained throughput is 1 word/clk.
//   - No bubbles: with out_ready held at 1, back-to-back inputs appear back-to-back at the output.
//  Mode rules, with carry = sum[WIDTH]:
//   - 00 KEEP: over ? data : sum[WIDTH-1:0] (wraps). incr=!over. ovf=!over&&carry.
//   - 01 SAT: over ? data : (carry ? all-ones : sum). incr=!over. ovf=!over&&carry.
//   - 10 CLAMP: over ? THRESHOLD : min(sum, THRESHOLD), where sum is taken with its carry bit.
//     incr = !over && (sum<=THRESHOLD). ovf=0.
//   - 11 ALWAYS: sum[WIDTH-1:0] (wraps). incr=1. ovf=carry.
//  Mode 00 with STEP=1, WIDTH=32, THRESHOLD=4096 is the legacy main/compare/increment function.
//  inc_count:
//   - +1 on each output transfer with out_incr=1; holds at 2**CNT_W-1.
//   - count_clr=1 wins over a simultaneous increment; the result is 0 that cycle.
//  Boundaries:
//   - data==THRESHOLD is not over, so it increments.
//   - data=2**WIDTH-1 in a non-over mode: 00 gives 0 with ovf=1; 01 gives all-ones with ovf=1.
//   - Input transfer and output transfer in the same cycle with a full pipe are legal.
//   - rst_n asserted mid-stream drops all in-flight words. No output appears for them.
// TESTING
//  T1 legacy: mode 00, in 100, 4096, 4097, 0 -> out 101, 4097, 4097, 1; incr 1,1,0,1; inc_count=3.
//  T2 wrap/sat: WIDTH=8, THRESHOLD=255, in 0xFF, modes 00 -> 0x00 with ovf=1, 01 -> 0xFF with ovf=1.
//  T3 clamp: mode 10, STEP=10, in 4090 -> 4096 incr=0; in 4000 -> 4010 incr=1; in 5000 -> 4096.
//  T4 back-pressure: 8 back-to-back words, out_ready random 50%.
//   -> all 8 arrive in order, unchanged while stalled; in_ready=0 only when both stages are full.
//  T5 throughput: out_ready=1, 16 consecutive inputs -> 16 consecutive outputs starting 2 cycles later.
//  T6 count/reset: CNT_W=2, 5 incremented words -> inc_count=3; count_clr during a transfer -> 0.
//   Then rst_n pulsed low with 2 words in flight -> out_valid=0 and neither word is delivered.

Source files
------------

// File: rtl/cond_increment_stream.sv
// Two-stage valid/ready pipeline: S1 captures the compare and the widened sum, and S2 applies the per-word mode rule.
// A saturating counter tracks how many delivered words carried the increment.
module cond_increment_stream #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned THRESHOLD = 4096,
  parameter int unsigned STEP      = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_incr,
  output logic             out_ovf,
  input  logic             count_clr,
  output logic [CNT_W-1:0] inc_count
);

  localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);
  localparam logic [WIDTH:0]   STP = (WIDTH+1)'(STEP);

  typedef enum logic [1:0] {
    M_KEEP   = 2'b00,
    M_SAT    = 2'b01,
    M_CLAMP  = 2'b10,
    M_ALWAYS = 2'b11
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    mode_e            mode;
    logic             over;
    logic [WIDTH:0]   sum;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             incr;
    logic             ovf;
  } s2_t;

  logic [2:1]       vld_pipe_q, vld_pipe_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [CNT_W-1:0] inc_count_q, inc_count_d;

  logic s1_load, s2_load, in_fire, out_fire;
  logic carry;
  s2_t  res;

  always_comb begin
    s2_load  = !vld_pipe_q[2] || out_ready;
    s1_load  = !vld_pipe_q[1] || s2_load;
    // Held low during reset so no word can be accepted into a clearing pipe.
    in_ready = rst_n && s1_load;
    in_fire  = in_valid && in_ready;
    out_fire = vld_pipe_q[2] && out_ready;
  end

  always_comb begin
    res   = '0;
    carry = s1_q.sum[WIDTH];
    case (s1_q.mode)
      M_KEEP: begin
        res.data = s1_q.over ? s1_q.data : s1_q.sum[WIDTH-1:0];
        res.incr = !s1_q.over;
        res.ovf  = !s1_q.over && carry;
      end
      M_SAT: begin
        res.data = s1_q.over ? s1_q.data : (carry ? '1 : s1_q.sum[WIDTH-1:0]);
        res.incr = !s1_q.over;
        res.ovf  = !s1_q.over && carry;
      end
      M_CLAMP: begin
        // Compare uses the carry bit, so a wrapped sum still clamps.
        if (s1_q.over || (s1_q.sum > {1'b0, THR})) res.data = THR;
        else                                        res.data = s1_q.sum[WIDTH-1:0];
        res.incr = !s1_q.over && (s1_q.sum <= {1'b0, THR});
        res.ovf  = 1'b0;
      end
      default: begin
        res.data = s1_q.sum[WIDTH-1:0];
        res.incr = 1'b1;
        res.ovf  = carry;
      end
    endcase
  end

  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    inc_count_d = inc_count_q;
    if (s1_load) begin
      vld_pipe_d[1] = in_fire;
      if (in_fire) begin
        s1_d.data = in_data;
        s1_d.mode = mode_e'(in_mode);
        s1_d.over = in_data > THR;
        s1_d.sum  = {1'b0, in_data} + STP;
      end
    end
    if (s2_load) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) s2_d = res;
    end
    if (count_clr)
      inc_count_d = '0;
    else if (out_fire && s2_q.incr && (inc_count_q != '1))
      inc_count_d = inc_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      inc_count_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      inc_count_q <= inc_count_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_data  = s2_q.data;
  assign out_incr  = s2_q.incr;
  assign out_ovf   = s2_q.ovf;
  assign inc_count = inc_count_q;

endmodule

// File: tb/tb_cond_increment_stream.sv
// Three configurations share one stimulus stream: legacy 32-bit, 8-bit with a 2-bit counter, and 16-bit with STEP=10.
// A queue-based reference model predicts the data, timing, ready and count outputs every cycle.
module tb_cond_increment_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, count_clr;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  bit          rdy_rand, rdy_fix;

  logic        in_ready0, out_valid0, out_incr0, out_ovf0;
  logic [31:0] out_data0;
  logic [15:0] inc_count0;
  logic        in_ready1, out_valid1, out_incr1, out_ovf1;
  logic [7:0]  out_data1;
  logic [1:0]  inc_count1;
  logic        in_ready2, out_valid2, out_incr2, out_ovf2;
  logic [15:0] out_data2;
  logic [15:0] inc_count2;

  cond_increment_stream #(.WIDTH(32), .THRESHOLD(4096), .STEP(1), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_incr(out_incr0), .out_ovf(out_ovf0),
    .count_clr(count_clr), .inc_count(inc_count0));

  cond_increment_stream #(.WIDTH(8), .THRESHOLD(255), .STEP(1), .CNT_W(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data[7:0]), .in_mode(in_mode), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_incr(out_incr1), .out_ovf(out_ovf1),
    .count_clr(count_clr), .inc_count(inc_count1));

  cond_increment_stream #(.WIDTH(16), .THRESHOLD(4096), .STEP(10), .CNT_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data[15:0]), .in_mode(in_mode), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_incr(out_incr2), .out_ovf(out_ovf2),
    .count_clr(count_clr), .inc_count(inc_count2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  int     cfg_w[3]    = '{32, 8, 16};
  int     cfg_cw[3]   = '{16, 2, 16};
  longint cfg_thr[3]  = '{4096, 255, 4096};
  longint cfg_step[3] = '{1, 1, 10};

  typedef struct { longint d; int m; int t; } ent_t;
  typedef struct { longint d; bit inc; bit ovf; } res_t;
  ent_t q[$];
  res_t got0[$], got1[$], got2[$];
  int   cnt[3];
  int   cyc = 0;
  int   checks = 0, failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic statement of the mode rules on a word truncated to the lane width.
  function automatic void model(input int k, input longint d, input int m,
                                output longint r, output bit inc, output bit ovf);
    longint lim, x, s, thr;
    bit     over;
    lim  = longint'(1) << cfg_w[k];
    x    = d % lim;
    s    = x + cfg_step[k];
    thr  = cfg_thr[k];
    over = x > thr;
    case (m)
      0: begin r = over ? x : s % lim; inc = !over; ovf = !over && (s >= lim); end
      1: begin r = over ? x : ((s >= lim) ? lim - 1 : s); inc = !over; ovf = !over && (s >= lim); end
      2: begin r = (over || s > thr) ? thr : s; inc = !over && (s <= thr); ovf = 1'b0; end
      default: begin r = s % lim; inc = 1'b1; ovf = s >= lim; end
    endcase
  endfunction

  always @(negedge clk) begin
    longint od[3], ic[3];
    bit     ov[3], ir[3], oi[3], oo[3];
    bit     ev, exp_ir, inc, ovf;
    longint r;
    res_t   rr;
    od[0] = longint'(out_data0); od[1] = longint'(out_data1); od[2] = longint'(out_data2);
    ic[0] = longint'(inc_count0); ic[1] = longint'(inc_count1); ic[2] = longint'(inc_count2);
    ov = '{out_valid0, out_valid1, out_valid2};
    ir = '{in_ready0, in_ready1, in_ready2};
    oi = '{out_incr0, out_incr1, out_incr2};
    oo = '{out_ovf0, out_ovf1, out_ovf2};
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst_valid%0d", k), longint'(ov[k]), 0);
        chk($sformatf("rst_ready%0d", k), longint'(ir[k]), 0);
        chk($sformatf("rst_data%0d", k), od[k], 0);
        chk($sformatf("rst_incr%0d", k), longint'(oi[k]), 0);
        chk($sformatf("rst_ovf%0d", k), longint'(oo[k]), 0);
        chk($sformatf("rst_count%0d", k), ic[k], 0);
        cnt[k] = 0;
      end
      q.delete();
    end else begin
      ev     = (q.size() > 0) && (q[0].t + 2 <= cyc);
      exp_ir = !((q.size() == 2) && !out_ready);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in_ready%0d", k), longint'(ir[k]), longint'(exp_ir));
        chk($sformatf("out_valid%0d", k), longint'(ov[k]), longint'(ev));
        if (ev) begin
          model(k, q[0].d, q[0].m, r, inc, ovf);
          chk($sformatf("out_data%0d", k), od[k], r);
          chk($sformatf("out_incr%0d", k), longint'(oi[k]), longint'(inc));
          chk($sformatf("out_ovf%0d", k), longint'(oo[k]), longint'(ovf));
        end
        chk($sformatf("inc_count%0d", k), ic[k], longint'(cnt[k]));
      end
      if (ev && out_ready) begin
        for (int k = 0; k < 3; k++) begin
          model(k, q[0].d, q[0].m, r, inc, ovf);
          if (inc && cnt[k] < (1 << cfg_cw[k]) - 1) cnt[k]++;
          rr.d = r; rr.inc = inc; rr.ovf = ovf;
          if (k == 0) got0.push_back(rr);
          else if (k == 1) got1.push_back(rr);
          else got2.push_back(rr);
        end
        void'(q.pop_front());
      end
      if (count_clr) cnt = '{0, 0, 0};
      if (in_valid && exp_ir) q.push_back('{longint'(in_data), int'(in_mode), cyc});
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input longint d, input int m);
    bit acc;
    int n;
    acc = 1'b0; n = 0;
    in_valid = 1'b1; in_data = d[31:0]; in_mode = m[1:0];
    while (!acc && n < 300) begin
      @(negedge clk); acc = in_ready0;
      @(posedge clk); #1; n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    step(n);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 400) begin step(1); n++; end
    chk("drain_empty", longint'(q.size()), 0);
  endtask

  task automatic pin(input string nm, input int which, input int idx,
                     input longint d, input longint inc, input longint ovf);
    res_t e;
    int   sz;
    case (which)
      0: sz = got0.size();
      1: sz = got1.size();
      default: sz = got2.size();
    endcase
    chk({nm, "_present"}, longint'(sz > idx), 1);
    if (sz > idx) begin
      case (which)
        0: e = got0[idx];
        1: e = got1[idx];
        default: e = got2[idx];
      endcase
      chk({nm, "_data"}, e.d, d);
      chk({nm, "_incr"}, longint'(e.inc), inc);
      chk({nm, "_ovf"}, longint'(e.ovf), ovf);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int     b;
    longint t0;
    longint d;
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; count_clr = 1'b0;
    rdy_rand = 1'b0; rdy_fix = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);
    chk("post_reset_ready", longint'(in_ready0), 1);

    // Legacy function on the 32-bit lane.
    b = got0.size();
    send(100, 0); send(4096, 0); send(4097, 0); send(0, 0);
    drain();
    pin("t1_w0", 0, b, 101, 1, 0);
    pin("t1_w1", 0, b + 1, 4097, 1, 0);
    pin("t1_w2", 0, b + 2, 4097, 0, 0);
    pin("t1_w3", 0, b + 3, 1, 1, 0);
    chk("t1_count", longint'(inc_count0), 3);

    // All-ones input on the 8-bit lane: wrap versus saturate.
    b = got1.size();
    send(255, 0); send(255, 1);
    drain();
    pin("t2_keep", 1, b, 0, 1, 1);
    pin("t2_sat", 1, b + 1, 255, 1, 1);

    // Clamp rule on the STEP=10 lane.
    b = got2.size();
    send(4090, 2); send(4000, 2); send(5000, 2);
    drain();
    pin("t3_w0", 2, b, 4096, 0, 0);
    pin("t3_w1", 2, b + 1, 4010, 1, 0);
    pin("t3_w2", 2, b + 2, 4096, 0, 0);

    // Back-pressure with a random consumer.
    rdy_rand = 1'b1;
    b = got0.size();
    for (int i = 0; i < 8; i++) send(longint'($urandom_range(0, 9000)), int'($urandom_range(0, 3)));
    drain();
    chk("t4_delivered", longint'(got0.size() - b), 8);
    rdy_rand = 1'b0; rdy_fix = 1'b1;
    step(2);

    // Throughput: 16 words must be accepted in 16 cycles.
    t0 = longint'($time);
    for (int i = 0; i < 16; i++) send(longint'(4080 + i), i % 4);
    chk("t5_cycles", (longint'($time) - t0) / 10, 16);
    drain();

    // Saturating 2-bit counter and clear priority.
    count_clr = 1'b1; idle(1); count_clr = 1'b0;
    chk("t6_clr", longint'(inc_count1), 0);
    for (int i = 0; i < 5; i++) send(longint'(10 * i), 0);
    drain();
    chk("t6_sat", longint'(inc_count1), 3);
    count_clr = 1'b1;
    send(1, 0); send(2, 0); send(3, 0);
    idle(3);
    count_clr = 1'b0;
    chk("t6_clr_xfer", longint'(inc_count1), 0);
    drain();

    // Reset with two words in flight.
    rdy_fix = 1'b0; step(1);
    send(10, 0); send(20, 0);
    idle(1);
    chk("t6_full_ready", longint'(in_ready0), 0);
    b = got0.size();
    rst_n = 1'b0; step(2);
    rst_n = 1'b1; rdy_fix = 1'b1;
    step(6);
    chk("t6_rst_dropped", longint'(got0.size() - b), 0);
    chk("t6_rst_valid", longint'(out_valid0), 0);

    // Random traffic biased toward the boundaries of every lane.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 8))
        0: d = 0;
        1: d = 4095;
        2: d = 4096;
        3: d = 4097;
        4: d = 64'hFFFF_FFFF;
        5: d = 255;
        6: d = 16'hFFF6;
        7: d = 4090;
        default: d = longint'($urandom);
      endcase
      count_clr = ($urandom_range(0, 15) == 0);
      send(d, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 2)));
    end
    count_clr = 1'b0;
    drain();
    rdy_rand = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
